// File: rtl/fft_frame_seq.sv
// Frame sequencer between the ADC capture path, an AXI-stream style FFT core and the spectrum RAM.
// Runs key-triggered single frames or back-to-back frames in continuous mode, with sticky error flags.
module fft_frame_seq #(
    parameter int FFT_N  = 1024,
    parameter int CNT_W  = 10,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            key,
    input  logic [DATA_W-1:0]     adc_data,
    input  logic                  adc_valid,
    output logic [DATA_W-1:0]     fft_s_data,
    output logic                  fft_s_valid,
    output logic                  fft_s_last,
    input  logic                  fft_s_ready,
    input  logic [2*DATA_W-1:0]   fft_m_data,
    input  logic                  fft_m_valid,
    input  logic                  fft_m_last,
    output logic                  fft_m_ready,
    output logic                  ram_wr_en,
    output logic [CNT_W-1:0]      ram_wr_addr,
    output logic [2*DATA_W-1:0]   ram_wr_data,
    output logic                  busy,
    output logic                  cont_mode,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  len_err
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FFT_N - 1);

    state_t                state_q, state_d;
    logic [1:0]            key_d0_q, key_d0_d;
    logic [1:0]            key_d1_q, key_d1_d;
    logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0]     s_data_q, s_data_d;
    logic                  s_valid_q, s_valid_d;
    logic                  wr_en_q, wr_en_d;
    logic [CNT_W-1:0]      wr_addr_q, wr_addr_d;
    logic [2*DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                  cont_q, cont_d;
    logic                  ovr_q, ovr_d;
    logic                  lerr_q, lerr_d;

    logic [1:0]            key_req;
    logic                  s_hs;
    logic                  s_last;
    logic                  bin_end;

    always_comb begin
        state_d   = state_q;
        key_d0_d  = key;
        key_d1_d  = key_d0_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        s_data_d  = s_data_q;
        s_valid_d = s_valid_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cont_d    = cont_q;
        ovr_d     = ovr_q;
        lerr_d    = lerr_q;

        // Keys are active-low: a request is a synchronised high-to-low transition.
        key_req = key_d1_q & ~key_d0_q;
        s_hs    = s_valid_q && fft_s_ready;
        s_last  = s_valid_q && (in_cnt_q == CNT_MAX);
        bin_end = (out_cnt_q == CNT_MAX);

        if (state_q == S_IDLE) begin
            if (|key_req) begin
                ovr_d  = 1'b0;
                lerr_d = 1'b0;
                if (key_req[1]) cont_d = 1'b1;
            end
        end else if (key_req[1]) begin
            cont_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (|key_req) state_d = S_FILL;
            end
            S_FILL: begin
                if (s_hs) in_cnt_d = in_cnt_q + 1'b1;
                if (s_hs && s_last) begin
                    s_valid_d = 1'b0;
                    state_d   = S_DRAIN;
                end else if (adc_valid && (!s_valid_q || fft_s_ready)) begin
                    s_data_d  = adc_data;
                    s_valid_d = 1'b1;
                end else begin
                    if (s_hs) s_valid_d = 1'b0;
                    if (adc_valid && s_valid_q && !fft_s_ready) ovr_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (fft_m_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = out_cnt_q;
                    wr_data_d = fft_m_data;
                    out_cnt_d = out_cnt_q + 1'b1;
                    // Leave on whichever end marker arrives first; a disagreement is flagged.
                    if (bin_end || fft_m_last) state_d = S_DONE;
                    if (bin_end != fft_m_last) lerr_d = 1'b1;
                end
            end
            S_DONE: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                state_d   = cont_d ? S_FILL : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            key_d0_q  <= 2'b11;
            key_d1_q  <= 2'b11;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cont_q    <= 1'b0;
            ovr_q     <= 1'b0;
            lerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_d0_q  <= key_d0_d;
            key_d1_q  <= key_d1_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            s_data_q  <= s_data_d;
            s_valid_q <= s_valid_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cont_q    <= cont_d;
            ovr_q     <= ovr_d;
            lerr_q    <= lerr_d;
        end
    end

    assign fft_s_data  = s_data_q;
    assign fft_s_valid = s_valid_q;
    assign fft_s_last  = s_last;
    assign fft_m_ready = (state_q == S_DRAIN);
    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign busy        = (state_q != S_IDLE);
    assign cont_mode   = cont_q;
    assign frame_done  = (state_q == S_DONE);
    assign overrun     = ovr_q;
    assign len_err     = lerr_q;

endmodule

// File: tb/tb_fft_frame_seq.sv
// Directed bench for fft_frame_seq: single frames, backpressure, continuous mode, early last, mid-frame reset.
module tb_fft_frame_seq;

    localparam int FFT_N  = 1024;
    localparam int CNT_W  = 10;
    localparam int DATA_W = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            key;
    logic [DATA_W-1:0]     adc_data;
    logic                  adc_valid;
    logic [DATA_W-1:0]     fft_s_data;
    logic                  fft_s_valid;
    logic                  fft_s_last;
    logic                  fft_s_ready;
    logic [2*DATA_W-1:0]   fft_m_data;
    logic                  fft_m_valid;
    logic                  fft_m_last;
    logic                  fft_m_ready;
    logic                  ram_wr_en;
    logic [CNT_W-1:0]      ram_wr_addr;
    logic [2*DATA_W-1:0]   ram_wr_data;
    logic                  busy;
    logic                  cont_mode;
    logic                  frame_done;
    logic                  overrun;
    logic                  len_err;

    int n_tests = 0;
    int n_fail  = 0;
    int samp    = 0;
    int f_cycles, f_bad, f_last;

    always #5 clk = ~clk;

    fft_frame_seq #(.FFT_N(FFT_N), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .key(key),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .fft_s_data(fft_s_data), .fft_s_valid(fft_s_valid), .fft_s_last(fft_s_last),
        .fft_s_ready(fft_s_ready),
        .fft_m_data(fft_m_data), .fft_m_valid(fft_m_valid), .fft_m_last(fft_m_last),
        .fft_m_ready(fft_m_ready),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .busy(busy), .cont_mode(cont_mode), .frame_done(frame_done),
        .overrun(overrun), .len_err(len_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; holds the key low until busy rises.
    task automatic press(input int b);
        key[b] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy === 1'b1) break;
        end
        chk("busy_after_key", busy, 1);
        key = 2'b11;
    endtask

    // Called at a negedge with the DUT in FILL. Models the one-entry holding register.
    task automatic fill(input int stall_at, input int key1_at, input int stop_at);
        logic              mv, rdy, dohs;
        logic [DATA_W-1:0] md;
        int                hs, stalls, kcnt;
        mv = 1'b0; md = '0; hs = 0; stalls = 0; kcnt = -1;
        f_cycles = 0; f_bad = 0; f_last = -1;
        while (1) begin
            if (stop_at >= 0 && hs == stop_at) break;
            rdy = 1'b1;
            if (stall_at >= 0 && hs == stall_at && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end
            if (key1_at >= 0 && hs == key1_at && kcnt < 0) begin
                key[1] = 1'b0;
                kcnt = 0;
            end else if (kcnt >= 0 && kcnt < 4) begin
                kcnt++;
                if (kcnt == 4) key[1] = 1'b1;
            end
            fft_s_ready = rdy;
            adc_valid   = 1'b1;
            adc_data    = DATA_W'(samp);
            samp++;
            f_cycles++;
            if (fft_s_valid !== mv) f_bad++;
            if (fft_s_last !== (mv && hs == FFT_N - 1)) f_bad++;
            dohs = mv && rdy;
            if (dohs) begin
                if (fft_s_data !== md) f_bad++;
                if (fft_s_last === 1'b1) f_last = hs;
            end
            if (dohs && hs == FFT_N - 1) break;
            if (!mv || rdy) begin
                md = adc_data;
                mv = 1'b1;
            end
            if (dohs) hs++;
            if (f_cycles > 4000) begin
                f_bad++;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at the negedge of the final input handshake; returns at the negedge of DONE.
    task automatic drain(input int nbins, input int tag);
        int bad;
        bad = 0;
        for (int i = 0; i < nbins; i++) begin
            @(negedge clk);
            if (i == 0) begin
                adc_valid = 1'b0;
                chk("m_ready_in_drain", fft_m_ready, 1);
                if (ram_wr_en !== 1'b0) bad++;
            end else if (ram_wr_en !== 1'b1 || ram_wr_addr !== CNT_W'(i - 1) ||
                         ram_wr_data !== {DATA_W'(tag), DATA_W'(i - 1)}) begin
                bad++;
            end
            fft_m_valid = 1'b1;
            fft_m_data  = {DATA_W'(tag), DATA_W'(i)};
            fft_m_last  = (i == nbins - 1);
        end
        @(negedge clk);
        fft_m_valid = 1'b0;
        fft_m_last  = 1'b0;
        chk("bins_written_in_order", bad, 0);
        chk("last_wr_en", ram_wr_en, 1);
        chk("last_wr_addr", ram_wr_addr, nbins - 1);
        chk("last_wr_data", ram_wr_data, {DATA_W'(tag), DATA_W'(nbins - 1)});
        chk("frame_done_pulse", frame_done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; key = 2'b11; adc_data = '0; adc_valid = 1'b0; fft_s_ready = 1'b0;
        fft_m_data = '0; fft_m_valid = 1'b0; fft_m_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_s_valid", fft_s_valid, 0);
        chk("rst_s_data", fft_s_data, 0);
        chk("rst_m_ready", fft_m_ready, 0);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_cont", cont_mode, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_len_err", len_err, 0);

        // Single frame, no backpressure.
        press(0);
        chk("f1_cont", cont_mode, 0);
        fill(-1, -1, -1);
        chk("f1_fill_stream", f_bad, 0);
        chk("f1_last_index", f_last, FFT_N - 1);
        chk("f1_fill_cycles", f_cycles, 1025);
        drain(FFT_N, 1);
        @(negedge clk);
        chk("f1_idle", busy, 0);
        chk("f1_done_1cycle", frame_done, 0);
        chk("f1_len_err", len_err, 0);
        chk("f1_overrun", overrun, 0);

        // Three cycles of backpressure drop three samples.
        press(0);
        fill(100, -1, -1);
        chk("f2_fill_stream", f_bad, 0);
        chk("f2_last_index", f_last, FFT_N - 1);
        chk("f2_fill_cycles", f_cycles, 1028);
        chk("f2_overrun", overrun, 1);
        drain(FFT_N, 2);
        @(negedge clk);
        chk("f2_idle", busy, 0);
        chk("f2_overrun_sticky", overrun, 1);

        // Continuous mode: three frames, key1 again during the third.
        press(1);
        chk("c_cont_on", cont_mode, 1);
        chk("c_overrun_cleared", overrun, 0);
        for (int f = 0; f < 3; f++) begin
            fill(-1, (f == 2) ? 200 : -1, -1);
            chk("c_fill_stream", f_bad, 0);
            chk("c_last_index", f_last, FFT_N - 1);
            drain(FFT_N, 3 + f);
            @(negedge clk);
            if (f < 2) begin
                chk("c_still_busy", busy, 1);
                chk("c_cont_kept", cont_mode, 1);
            end else begin
                chk("c_cont_off", cont_mode, 0);
                chk("c_idle_after_3", busy, 0);
            end
        end

        // Early fft_m_last at bin 500.
        press(0);
        fill(-1, -1, -1);
        chk("e_fill_stream", f_bad, 0);
        drain(501, 6);
        chk("e_len_err", len_err, 1);
        @(negedge clk);
        chk("e_idle", busy, 0);
        chk("e_len_err_sticky", len_err, 1);

        // Reset mid-frame at in_cnt 300, then a clean restart.
        press(0);
        chk("r_len_err_cleared", len_err, 0);
        fill(-1, -1, 300);
        rst = 1'b1;
        adc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("r_busy", busy, 0);
        chk("r_s_valid", fft_s_valid, 0);
        chk("r_s_last", fft_s_last, 0);
        chk("r_s_data", fft_s_data, 0);
        chk("r_m_ready", fft_m_ready, 0);
        chk("r_wr_en", ram_wr_en, 0);
        chk("r_wr_addr", ram_wr_addr, 0);
        chk("r_wr_data", ram_wr_data, 0);
        chk("r_done", frame_done, 0);
        @(negedge clk);
        press(0);
        fill(-1, -1, -1);
        chk("r2_fill_stream", f_bad, 0);
        chk("r2_last_index", f_last, FFT_N - 1);
        chk("r2_fill_cycles", f_cycles, 1025);
        drain(FFT_N, 7);
        @(negedge clk);
        chk("r2_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
